// File: rtl/arb_pkg.sv
// arb_pkg: shared types, default sizes and helpers for the round-robin address arbiter
package arb_pkg;
  localparam int N_DEF = 16;
  localparam int AW_DEF = 4;
  localparam int HOLD_MAX_DEF = 8;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic logic [AW_DEF-1:0] onehot2bin(input logic [N_DEF-1:0] oh);
    onehot2bin = '0;
    for (int i = 0; i < N_DEF; i++) if (oh[i]) onehot2bin = onehot2bin | AW_DEF'(i);
  endfunction
endpackage

// File: rtl/rr_prio_pick.sv
// rr_prio_pick: rotating priority picker, first set req bit at or after ptr (wrapping)
module rr_prio_pick import arb_pkg::*; #(
  parameter int N = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic          any,
  output logic [AW-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [AW-1:0] off;
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  assign any = |req;
  assign idx = ptr + off;
  // fixed priority encode of the rotated vector; lowest set bit wins
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = AW'(i);
  end
endmodule

// File: rtl/rr_addr_arbiter.sv
// rr_addr_arbiter: round-robin grant of one shared address resource; ARB_TIMEOUT_EN adds a hold-time limit
module rr_addr_arbiter import arb_pkg::*; #(
  parameter int N = N_DEF,
`ifdef ARB_TIMEOUT_EN
  parameter int HOLD_MAX = HOLD_MAX_DEF,
`endif
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic          gnt_valid,
  output logic [N-1:0]  gnt_onehot,
  output logic [AW-1:0] gnt_addr,
  output logic          busy,
  output logic          timeout
);
  arb_state_t state, state_n;
  logic [AW-1:0] ptr, ptr_n, addr_n, idx;
  logic [N-1:0] oh_n;
  logic valid_n, any, rel;
  rr_prio_pick #(.N(N), .AW(AW)) u_pick (.req(req), .ptr(ptr), .any(any), .idx(idx));
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic expire, to_n;
  assign expire = cnt == CW'(HOLD_MAX - 1);
  assign rel = done | ~req[gnt_addr] | expire;
`else
  assign rel = done | ~req[gnt_addr];
  assign timeout = 1'b0;
`endif
  // next-state: grant from IDLE, release from GRANT (no back-to-back grants)
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    valid_n = gnt_valid;
    oh_n = gnt_onehot;
    addr_n = gnt_addr;
`ifdef ARB_TIMEOUT_EN
    cnt_n = cnt;
    to_n = 1'b0;
`endif
    if (state == IDLE) begin
      if (any) begin
        state_n = GRANT;
        valid_n = 1'b1;
        oh_n = N'(1) << idx;
        addr_n = idx;
`ifdef ARB_TIMEOUT_EN
        cnt_n = '0;
`endif
      end
    end else if (rel) begin
      state_n = IDLE;
      valid_n = 1'b0;
      oh_n = '0;
      addr_n = '0;
      ptr_n = gnt_addr + 1'b1;
`ifdef ARB_TIMEOUT_EN
      to_n = ~done & req[gnt_addr];
      cnt_n = '0;
    end else begin
      cnt_n = cnt + 1'b1;
`endif
    end
  end
  // state, pointer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      gnt_valid <= 1'b0;
      gnt_onehot <= '0;
      gnt_addr <= '0;
      busy <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      gnt_valid <= valid_n;
      gnt_onehot <= oh_n;
      gnt_addr <= addr_n;
      busy <= state_n == GRANT;
`ifdef ARB_TIMEOUT_EN
      cnt <= cnt_n;
      timeout <= to_n;
`endif
    end
  end
endmodule

// File: tb/tb_rr_addr_arbiter.sv
// tb_rr_addr_arbiter: scoreboard bench for rr_addr_arbiter (honours ARB_TIMEOUT_EN)
module tb_rr_addr_arbiter;
  typedef struct packed {
    logic v;
    logic [15:0] oh;
    logic [3:0] a;
    logic b;
    logic t;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] req = '0;
  logic done = 1'b0;
  logic gnt_valid, busy, timeout;
  logic [15:0] gnt_onehot;
  logic [3:0] gnt_addr;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  bit m_busy = 0;
  int m_ptr = 0, m_addr = 0, m_cnt = 0;
  rr_addr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .gnt_valid(gnt_valid),
    .gnt_onehot(gnt_onehot), .gnt_addr(gnt_addr), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic step(input logic [15:0] r, input logic d);
    exp_t e;
    bit found, expire, t;
    req = r;
    done = d;
    t = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < 16; k++) begin
        int j;
        j = (m_ptr + k) % 16;
        if (!found && r[j]) begin
          found = 1;
          m_addr = j;
        end
      end
      if (found) begin
        m_busy = 1;
        m_cnt = 0;
      end
    end else begin
`ifdef ARB_TIMEOUT_EN
      expire = (m_cnt + 1) >= 8;
`else
      expire = 0;
`endif
      if (d || !r[m_addr] || expire) begin
        t = expire && !d && r[m_addr];
        m_busy = 0;
        m_ptr = (m_addr + 1) % 16;
      end else m_cnt++;
    end
    e.v = m_busy;
    e.oh = m_busy ? 16'(1) << m_addr : 16'h0;
    e.a = m_busy ? 4'(m_addr) : 4'h0;
    e.b = m_busy;
    e.t = t;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) chk("queue_empty", 0, 1);
    else begin
      e = q.pop_front();
      chk("gnt_valid", 32'(gnt_valid), 32'(e.v));
      chk("gnt_onehot", 32'(gnt_onehot), 32'(e.oh));
      chk("gnt_addr", 32'(gnt_addr), 32'(e.a));
      chk("busy", 32'(busy), 32'(e.b));
      chk("timeout", 32'(timeout), 32'(e.t));
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(gnt_valid), 0);
    chk("rst_onehot", 32'(gnt_onehot), 0);
    chk("rst_addr", 32'(gnt_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    m_busy = 0;
    m_ptr = 0;
    m_addr = 0;
    m_cnt = 0;
    req = '0;
    done = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    step(16'h0020, 0);
    step(16'h0020, 0);
    chk("pre_rst_addr", 32'(gnt_addr), 5);
    #2;
    do_reset();
    step(16'h0020, 0);
    chk("post_rst_addr", 32'(gnt_addr), 5);
    step(16'h0000, 0);
    do_reset();
    step(16'hFFFE, 0);
    step(16'hFFFE, 1);
    step(16'hFFFE, 0);
    chk("seq_addr2", 32'(gnt_addr), 2);
    step(16'hFFFE, 1);
    step(16'h0000, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(16'h8001, 0);
      step(16'h8001, 1);
    end
    step(16'h0000, 1);
    step(16'h0000, 0);
    step(16'h0000, 1);
    do_reset();
    step(16'h0008, 0);
    step(16'h0000, 0);
    step(16'h010F, 0);
    chk("after_drop_addr", 32'(gnt_addr), 8);
    step(16'h0000, 0);
    do_reset();
    for (int i = 0; i < 100; i++) step(16'h0010, 0);
    step(16'h0000, 0);
    do_reset();
    step(16'h0006, 0);
    step(16'h0006, 1);
    step(16'h0006, 0);
    chk("same_edge_addr", 32'(gnt_addr), 2);
    step(16'h0000, 0);
    if (q.size() != 0) chk("queue_left", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
